// File: rtl/smc777_mem_arbiter_if.sv
// smc777_mem_arbiter_if: requester, download and RAM signals shared by the SMC-777 memory arbiter
interface smc777_mem_arbiter_if;
  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        ioctl_wait;
  logic        vid_req;
  logic [15:0] vid_addr;
  logic [7:0]  vid_data;
  logic        vid_valid;
  logic        cpu_req;
  logic        cpu_we;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_din;
  logic [7:0]  cpu_dout;
  logic        cpu_ack;
  logic        cpu_hold;
  logic        mem_ce;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic        dl_done;
  logic [16:0] dl_count;
  modport slave (
    input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
    input  vid_req, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_din, mem_dout,
    output ioctl_wait, vid_data, vid_valid, cpu_dout, cpu_ack, cpu_hold,
    output mem_ce, mem_we, mem_addr, mem_din, dl_done, dl_count
  );
  modport master (
    output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
    output vid_req, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_din, mem_dout,
    input  ioctl_wait, vid_data, vid_valid, cpu_dout, cpu_ack, cpu_hold,
    input  mem_ce, mem_we, mem_addr, mem_din, dl_done, dl_count
  );
endinterface

// File: rtl/smc777_mem_arbiter.sv
// smc777_mem_arbiter: shares one synchronous RAM port between video, ioctl download and CPU
module smc777_mem_arbiter #(
  parameter logic [7:0]  DL_INDEX = 8'd0,
  parameter logic [15:0] DL_BASE  = 16'h0000
) (
  input logic clk,
  input logic reset,
  smc777_mem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, LOADING, DRAIN} state_t;
  state_t      state, state_nx;
  logic        dl_active, dl_active_q, dl_rise, load;
  logic        buf_full;
  logic [15:0] buf_addr;
  logic [7:0]  buf_data;
  logic        g_vid, g_dl, g_cpu;
  logic        cpu_pend, cpu_ack_q, vid_valid_q, hold_q;
  logic [7:0]  vid_last, cpu_last;
  logic [16:0] count;
  assign dl_active = bus.ioctl_download && (bus.ioctl_index == DL_INDEX);
  assign dl_rise   = dl_active && !dl_active_q;
  assign load      = dl_active && bus.ioctl_wr && (bus.ioctl_addr[24:16] == '0) && !buf_full;
  assign g_vid = !reset && bus.vid_req;
  assign g_dl  = buf_full && !bus.vid_req;
  assign g_cpu = !reset && bus.cpu_req && !hold_q && !bus.vid_req && !buf_full && !cpu_pend && !cpu_ack_q;
  assign bus.mem_ce   = g_vid || g_dl || g_cpu;
  assign bus.mem_we   = g_dl || (g_cpu && bus.cpu_we);
  assign bus.mem_addr = g_vid ? bus.vid_addr : g_dl ? buf_addr : g_cpu ? bus.cpu_addr : '0;
  assign bus.mem_din  = g_dl ? buf_data : (g_cpu && bus.cpu_we) ? bus.cpu_din : '0;
  assign bus.ioctl_wait = buf_full;
  assign bus.vid_valid  = vid_valid_q;
  assign bus.vid_data   = vid_valid_q ? bus.mem_dout : vid_last;
  assign bus.cpu_ack    = cpu_ack_q;
  assign bus.cpu_dout   = cpu_pend ? bus.mem_dout : cpu_last;
  assign bus.cpu_hold   = hold_q;
  assign bus.dl_count   = count;
  // Download buffer, CPU hold, return tagging and byte counter
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      dl_active_q <= 1'b0;
      buf_full    <= 1'b0;
      buf_addr    <= '0;
      buf_data    <= '0;
      hold_q      <= 1'b0;
      cpu_pend    <= 1'b0;
      cpu_ack_q   <= 1'b0;
      vid_valid_q <= 1'b0;
      vid_last    <= '0;
      cpu_last    <= '0;
      count       <= '0;
    end else begin
      dl_active_q <= dl_active;
      buf_full    <= load || (buf_full && !g_dl);
      if (load) begin
        buf_addr <= DL_BASE + bus.ioctl_addr[15:0];
        buf_data <= bus.ioctl_dout;
      end
      hold_q      <= dl_active || buf_full;
      cpu_pend    <= g_cpu && !bus.cpu_we;
      cpu_ack_q   <= g_cpu;
      vid_valid_q <= g_vid;
      if (vid_valid_q) vid_last <= bus.mem_dout;
      if (cpu_pend) cpu_last <= bus.mem_dout;
      count <= dl_rise ? '0 : (g_dl && count != '1) ? count + 1'b1 : count;
    end
  // Completion FSM state register
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_nx;
  // Completion FSM next state; dl_done fires as the drained download returns to idle
  always_comb begin
    state_nx = state;
    bus.dl_done = 1'b0;
    state_nx = (state == IDLE)    ? (dl_active ? LOADING : IDLE) :
               (state == LOADING) ? (dl_active ? LOADING : DRAIN) :
               dl_active ? LOADING : buf_full ? DRAIN : IDLE;
    bus.dl_done = (state == DRAIN) && !dl_active && !buf_full;
  end
endmodule

// File: tb/tb_smc777_mem_arbiter.sv
// tb_smc777_mem_arbiter: directed and randomized checks of the SMC-777 memory arbiter
module tb_smc777_mem_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int vectors = 0;
  int errors = 0;
  logic [7:0]  ram [0:65535];
  logic        pre_we = 1'b0;
  logic [15:0] pre_a = '0;
  logic [7:0]  pre_d = '0;
  logic [7:0]  ref_mem [0:255];
  logic        cr, cw, gv, gc, exp_vv, exp_ack, exp_w;
  logic [15:0] ca;
  logic [7:0]  cd, exp_vd, exp_cd;
  int          n;
  smc777_mem_arbiter_if bus();
  smc777_mem_arbiter #(.DL_INDEX(8'd0), .DL_BASE(16'h8000)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  // Synchronous RAM macro with a preload port for the bench
  always @(posedge clk)
    if (pre_we) ram[pre_a] <= pre_d;
    else if (bus.mem_ce) begin
      if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_din;
      else bus.mem_dout <= ram[bus.mem_addr];
    end
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    bus.vid_req = 1'b0;
    bus.ioctl_wr = 1'b0;
    bus.cpu_req = 1'b0;
    bus.cpu_we = 1'b0;
  endtask
  task automatic poke(input logic [15:0] a, input logic [7:0] d);
    pre_we = 1'b1;
    pre_a = a;
    pre_d = d;
    nxt();
    pre_we = 1'b0;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  initial begin
    bus.ioctl_download = 1'b0;
    bus.ioctl_index = 8'd0;
    bus.ioctl_addr = '0;
    bus.ioctl_dout = '0;
    bus.vid_addr = '0;
    bus.cpu_addr = '0;
    bus.cpu_din = '0;
    bus.mem_dout = '0;
    idle();
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'($urandom);
    poke(16'h1234, 8'hA5);
    poke(16'h0200, 8'h3C);
    for (int i = 0; i < 256; i++) poke(16'h4000 + 16'(i), ref_mem[i]);
    nxt();
    reset = 1'b0;
    #3;
    chk("reset_flags", {bus.mem_ce, bus.ioctl_wait, bus.cpu_hold, bus.vid_valid, bus.cpu_ack, bus.dl_done}, 0);
    chk("reset_count", bus.dl_count, 0);
    // Video read
    nxt(); bus.vid_req = 1'b1; bus.vid_addr = 16'h1234; #3;
    chk("vid_ce", {bus.mem_ce, bus.mem_we}, 2'b10);
    chk("vid_addr", bus.mem_addr, 16'h1234);
    nxt(); idle(); #3;
    chk("vid_valid", bus.vid_valid, 1);
    chk("vid_data", bus.vid_data, 8'hA5);
    // Matching download of four bytes
    nxt(); bus.ioctl_download = 1'b1; bus.ioctl_index = 8'd0;
    for (int i = 0; i < 4; i++) begin
      nxt(); bus.ioctl_wr = 1'b1; bus.ioctl_addr = 25'(i); bus.ioctl_dout = 8'(8'h11 * (i + 1)); #3;
      chk("dl_wait_lo0", bus.ioctl_wait, 0);
      nxt(); bus.ioctl_wr = 1'b0; #3;
      chk("dl_wait_hi", bus.ioctl_wait, 1);
      chk("dl_we", {bus.mem_ce, bus.mem_we}, 2'b11);
      chk("dl_addr", bus.mem_addr, 16'h8000 + 16'(i));
      chk("dl_din", bus.mem_din, 8'(8'h11 * (i + 1)));
      chk("dl_hold", bus.cpu_hold, 1);
      nxt(); #3;
      chk("dl_wait_lo", bus.ioctl_wait, 0);
    end
    chk("dl_count4", bus.dl_count, 4);
    for (int i = 0; i < 4; i++) chk("dl_ram", ram[16'h8000 + 16'(i)], 8'(8'h11 * (i + 1)));
    nxt(); bus.ioctl_download = 1'b0; n = 0;
    for (int i = 0; i < 5; i++) begin #3; if (bus.dl_done) n++; nxt(); end
    chk("dl_done_once", n, 1);
    // Non-matching index is ignored
    bus.ioctl_download = 1'b1; bus.ioctl_index = 8'd3; n = 0;
    for (int i = 0; i < 2; i++) begin
      nxt(); bus.ioctl_wr = 1'b1; bus.ioctl_addr = 25'(i); #3;
      if (bus.mem_we) n++;
      nxt(); bus.ioctl_wr = 1'b0; #3;
      if (bus.mem_we || bus.ioctl_wait) n++;
    end
    nxt(); bus.ioctl_download = 1'b0;
    for (int i = 0; i < 4; i++) begin #3; if (bus.dl_done) n++; nxt(); end
    chk("idx3_ignored", n, 0);
    chk("idx3_count", bus.dl_count, 4);
    // Out-of-range address on the matching index
    bus.ioctl_download = 1'b1; bus.ioctl_index = 8'd0;
    nxt(); bus.ioctl_wr = 1'b1; bus.ioctl_addr = 25'h10000; #3;
    nxt(); bus.ioctl_wr = 1'b0; #3;
    chk("oor_drop", {bus.mem_ce, bus.ioctl_wait}, 0);
    chk("oor_count", bus.dl_count, 0);
    // Video, download and CPU requesting together
    nxt(); bus.vid_req = 1'b1; bus.vid_addr = 16'h1234;
    bus.ioctl_wr = 1'b1; bus.ioctl_addr = 25'd5; bus.ioctl_dout = 8'h77;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0200; #3;
    chk("mix_vid", {bus.mem_ce, bus.mem_we, bus.mem_addr}, {2'b10, 16'h1234});
    chk("mix_hold", bus.cpu_hold, 1);
    nxt(); bus.vid_req = 1'b0; bus.ioctl_wr = 1'b0; #3;
    chk("mix_dl", {bus.mem_ce, bus.mem_we, bus.mem_addr, bus.mem_din}, {2'b11, 16'h8005, 8'h77});
    nxt(); #3;
    chk("mix_cpu_held", {bus.mem_ce, bus.cpu_hold}, 2'b01);
    nxt(); bus.ioctl_download = 1'b0; #3;
    chk("mix_cpu_held2", bus.mem_ce, 0);
    nxt(); #3;
    chk("mix_cpu_grant", {bus.mem_ce, bus.mem_we, bus.mem_addr}, {2'b10, 16'h0200});
    nxt(); idle(); #3;
    chk("mix_cpu_ack", {bus.cpu_ack, bus.cpu_dout}, {1'b1, 8'h3C});
    // CPU write then read with request held
    nxt(); bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 16'h0100; bus.cpu_din = 8'h5A; #3;
    chk("cw_grant", {bus.mem_ce, bus.mem_we, bus.mem_addr, bus.mem_din}, {2'b11, 16'h0100, 8'h5A});
    nxt(); bus.cpu_we = 1'b0; #3;
    chk("cw_ack", {bus.cpu_ack, bus.mem_ce}, 2'b10);
    nxt(); #3;
    chk("cr_grant", {bus.mem_ce, bus.mem_we, bus.mem_addr, bus.cpu_ack}, {2'b10, 16'h0100, 1'b0});
    nxt(); idle(); #3;
    chk("cr_ack", {bus.cpu_ack, bus.cpu_dout}, {1'b1, 8'h5A});
    nxt(); #3;
    chk("cr_quiet", {bus.cpu_ack, bus.mem_ce}, 0);
    // Random video and CPU traffic against a memory-level reference
    cr = 1'b0; cw = 1'b0; ca = '0; cd = '0; exp_vv = 1'b0; exp_ack = 1'b0; exp_w = 1'b0; exp_vd = '0; exp_cd = '0;
    for (int c = 0; c < 600; c++) begin
      nxt();
      bus.vid_req = (c < 599) && ($urandom_range(0, 2) == 0);
      bus.vid_addr = 16'h4000 | 16'($urandom_range(0, 255));
      if (!cr && c < 599 && $urandom_range(0, 1) == 1) begin
        cr = 1'b1; cw = 1'($urandom); ca = 16'h4000 | 16'($urandom_range(0, 255)); cd = 8'($urandom);
      end
      bus.cpu_req = cr; bus.cpu_we = cw; bus.cpu_addr = ca; bus.cpu_din = cd;
      #3;
      chk("rnd_vvalid", bus.vid_valid, exp_vv);
      if (exp_vv) chk("rnd_vdata", bus.vid_data, exp_vd);
      chk("rnd_ack", bus.cpu_ack, exp_ack);
      if (exp_ack && !exp_w) chk("rnd_cdata", bus.cpu_dout, exp_cd);
      gv = bus.vid_req;
      gc = cr && !gv && !exp_ack;
      chk("rnd_ce", bus.mem_ce, gv || gc);
      if (gv) chk("rnd_vaddr", bus.mem_addr, bus.vid_addr);
      if (gc) chk("rnd_caddr", {bus.mem_we, bus.mem_addr}, {cw, ca});
      exp_vv = gv;
      if (gv) exp_vd = ref_mem[bus.vid_addr[7:0]];
      exp_ack = gc;
      exp_w = cw;
      if (gc) begin
        if (cw) ref_mem[ca[7:0]] = cd;
        else exp_cd = ref_mem[ca[7:0]];
        cr = (c < 598) && $urandom_range(0, 1) == 1;
        cw = 1'($urandom); ca = 16'h4000 | 16'($urandom_range(0, 255)); cd = 8'($urandom);
      end
    end
    nxt(); idle(); #3;
    chk("rnd_last_ack", bus.cpu_ack, exp_ack);
    // Reset with a buffered byte and an outstanding CPU read
    nxt(); bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h4000;
    bus.ioctl_download = 1'b1; bus.ioctl_index = 8'd0; bus.ioctl_wr = 1'b1; bus.ioctl_addr = 25'd9; bus.ioctl_dout = 8'hEE; #3;
    chk("rst_pre_grant", {bus.mem_ce, bus.mem_addr}, {1'b1, 16'h4000});
    nxt(); idle(); bus.vid_req = 1'b1;
    chk("rst_pre_full", bus.ioctl_wait, 1);
    reset = 1'b1; #1;
    chk("rst_flags", {bus.mem_ce, bus.mem_we, bus.ioctl_wait, bus.vid_valid, bus.cpu_ack, bus.cpu_hold, bus.dl_done}, 0);
    chk("rst_data", {bus.mem_addr, bus.mem_din, bus.vid_data, bus.cpu_dout, bus.dl_count}, 0);
    nxt(); nxt(); idle(); bus.ioctl_download = 1'b0; reset = 1'b0; n = 0;
    for (int i = 0; i < 4; i++) begin #3; if (bus.mem_ce || bus.cpu_ack || bus.vid_valid) n++; nxt(); end
    chk("rst_quiet", n, 0);
    chk("rst_no_write", ram[16'h8009], 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
